mem_access_unit: RTL and testbench

MEM-stage load/store initiator for the pipelined MIPS core. It drives the word-addressed data memory, which has a combinational read and a write on the clock edge. Word transfers pass straight through. Byte and halfword loads are extracted and sign- or zero-extended. Byte and halfword stores are performed as a two-cycle read-modify-write. Misaligned and out-of-range requests are detected and never reach memory.

---
 rtl/mem_access_unit.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store initiator for the pipelined MIPS core. It drives a
// word-addressed data memory that reads combinationally and writes on the
// rising clock edge.
//
//   * Word loads and stores pass straight through in a single cycle.
//   * Byte and halfword loads pick one lane of the read word and sign- or
//     zero-extend it.
//   * Byte and halfword stores run as a two-cycle read-modify-write: the
//     accept cycle reads the word, and the MERGE cycle writes it back with one
//     lane replaced.
//   * Misaligned, reserved-size and out-of-range requests never touch memory;
//     they answer with a one-cycle error response.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   req_valid      request present this cycle
//   req_ready      unit can accept (high exactly in IDLE)
//   req_write      1 = store, 0 = load
//   req_size       00 byte, 01 halfword, 10 word, 11 reserved (misaligned)
//   req_unsigned   loads only: 1 = zero-extend, 0 = sign-extend
//   req_addr       byte address
//   req_wdata      store data, right-justified
//   resp_valid     registered one-cycle completion pulse
//   load_data      extended load result (0 for stores and errors)
//   misalign_err   alignment fault / reserved size, qualified by resp_valid
//   range_err      address not below MEM_BYTES, qualified by resp_valid
//   mem_read       memory read enable
//   mem_write      memory write enable
//   mem_address    word-aligned memory address
//   mem_writedata  data written to memory
//   mem_readdata   combinational read data from memory
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic        range_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t      state;
  state_t      next_state;

  // Context of a sub-word store, held across the MERGE cycle.
  logic [31:0] merge_buf;
  logic [31:0] lat_addr;
  logic        lat_half;
  logic [15:0] lat_wdata;

  logic        misalign;
  logic        out_of_range;
  logic        req_err;
  logic        issue;
  logic        subword_store;
  logic [31:0] extended;

  // Select one lane of the read word and extend it to 32 bits. Word loads
  // come back unchanged.
  function automatic logic [31:0] extend_load(
    input logic [31:0] word,
    input logic [1:0]  size,
    input logic [1:0]  lane,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replace exactly one byte or halfword lane of the buffered word with the
  // store data; every other bit keeps its old memory value.
  function automatic logic [31:0] merge_lane(
    input logic [31:0] old_word,
    input logic        half,
    input logic [1:0]  lane,
    input logic [15:0] wdata
  );
    logic [31:0] r;
    r = old_word;
    if (half) begin
      if (lane[1]) r[31:16] = wdata;
      else         r[15:0]  = wdata;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = wdata[7:0];
        2'd1:    r[15:8]  = wdata[7:0];
        2'd2:    r[23:16] = wdata[7:0];
        default: r[31:24] = wdata[7:0];
      endcase
    end
    return r;
  endfunction

  // Request classification. The reserved size counts as misaligned, and the
  // range check is on the full byte address so aliasing above MEM_BYTES can
  // never slip through to memory.
  always_comb begin
    misalign      = 1'b0;
    out_of_range  = (req_addr >= MEM_BYTES);
    case (req_size)
      SIZE_BYTE: misalign = 1'b0;
      SIZE_HALF: misalign = req_addr[0];
      SIZE_WORD: misalign = (req_addr[1:0] != 2'b00);
      default:   misalign = 1'b1;
    endcase
    req_err       = misalign | out_of_range;
    issue         = req_valid & ~req_err;
    subword_store = req_write & (req_size != SIZE_WORD);
    extended      = extend_load(mem_readdata, req_size, req_addr[1:0], req_unsigned);
  end

  // Next state and memory-side outputs. In IDLE the memory controls follow
  // the request combinationally; in MERGE they come only from the latched
  // context, so the pipeline inputs are ignored. Because the write enable is
  // decoded from the state register, an asynchronous reset drops it at once.
  always_comb begin
    next_state    = state;
    req_ready     = (state == IDLE);
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = 32'b0;
    mem_writedata = 32'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          mem_address = {req_addr[31:2], 2'b00};
          if (req_write && req_size == SIZE_WORD) begin
            mem_write     = 1'b1;
            mem_writedata = req_wdata;
          end else begin
            mem_read = 1'b1;
          end
          if (subword_store) next_state = MERGE;
        end
      end
      MERGE: begin
        mem_write     = 1'b1;
        mem_address   = {lat_addr[31:2], 2'b00};
        mem_writedata = merge_lane(merge_buf, lat_half, lat_addr[1:0], lat_wdata);
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Response and read-modify-write context. The response registers default to
  // zero every cycle so resp_valid is a pulse, yet back-to-back single-cycle
  // requests keep it high on consecutive cycles. A store abandoned by reset
  // never reaches the MERGE response, so it produces no pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid   <= 1'b0;
      load_data    <= 32'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      merge_buf    <= 32'b0;
      lat_addr     <= 32'b0;
      lat_half     <= 1'b0;
      lat_wdata    <= 16'b0;
    end else begin
      resp_valid   <= 1'b0;
      load_data    <= 32'b0;
      misalign_err <= 1'b0;
      range_err    <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_err) begin
              resp_valid   <= 1'b1;
              misalign_err <= misalign;
              range_err    <= out_of_range;
            end else if (!req_write) begin
              resp_valid <= 1'b1;
              load_data  <= extended;
            end else if (req_size == SIZE_WORD) begin
              resp_valid <= 1'b1;
            end else begin
              merge_buf <= mem_readdata;
              lat_addr  <= req_addr;
              lat_half  <= (req_size == SIZE_HALF);
              lat_wdata <= req_wdata[15:0];
            end
          end
        end
        MERGE: resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misalign_err;
  logic        range_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;

  logic [31:0] mem [0:63];
  logic        bench_we;
  logic [5:0]  bench_idx;
  logic [31:0] bench_data;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_load;
    logic        exp_mis;
    logic        exp_rng;
  } vec_t;

  vec_t vecs [0:15];

  mem_access_unit #(.MEM_BYTES(256)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .range_err    (range_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_readdata (mem_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench memory: combinational read, write on the rising edge. The bench
  // port is only used for preloading while the DUT is idle.
  assign mem_readdata = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_write)     mem[mem_address[7:2]] <= mem_writedata;
    else if (bench_we) mem[bench_idx]        <= bench_data;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic preloadWord(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    bench_we   = 1'b1;
    bench_idx  = idx;
    bench_data = val;
    @(posedge clk);
    #1;
    bench_we = 1'b0;
  endtask

  task automatic setReq(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One single-cycle request: check the memory strobes in the accept cycle,
  // then the registered response one cycle later.
  task automatic applyStimulus(input int n, input vec_t v);
    @(negedge clk);
    setReq(v.wr, v.size, v.uns, v.addr, v.wdata);
    #1;
    checkOutput($sformatf("v%0d_mem_read", n), {31'b0, mem_read}, {31'b0, v.exp_rd});
    checkOutput($sformatf("v%0d_mem_write", n), {31'b0, mem_write}, {31'b0, v.exp_wr});
    checkOutput($sformatf("v%0d_wdata", n), mem_writedata, v.exp_wr ? v.wdata : 32'b0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput($sformatf("v%0d_resp_valid", n), {31'b0, resp_valid}, 32'd1);
    checkOutput($sformatf("v%0d_load_data", n), load_data, v.exp_load);
    checkOutput($sformatf("v%0d_misalign", n), {31'b0, misalign_err}, {31'b0, v.exp_mis});
    checkOutput($sformatf("v%0d_range", n), {31'b0, range_err}, {31'b0, v.exp_rng});
    checkOutput($sformatf("v%0d_ready", n), {31'b0, req_ready}, 32'd1);
  endtask

  // Sub-word store: read in cycle 0, merged write in cycle 1, response in 2.
  task automatic subwordStore(input string name, input logic half,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_word);
    @(negedge clk);
    setReq(1'b1, half ? 2'b01 : 2'b00, 1'b0, addr, wdata);
    #1;
    checkOutput({name, "_c0_read"}, {31'b0, mem_read}, 32'd1);
    checkOutput({name, "_c0_write"}, {31'b0, mem_write}, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput({name, "_c1_ready"}, {31'b0, req_ready}, 32'd0);
    checkOutput({name, "_c1_read"}, {31'b0, mem_read}, 32'd0);
    checkOutput({name, "_c1_write"}, {31'b0, mem_write}, 32'd1);
    checkOutput({name, "_c1_addr"}, mem_address, {addr[31:2], 2'b00});
    checkOutput({name, "_c1_wdata"}, mem_writedata, exp_word);
    checkOutput({name, "_c1_resp"}, {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput({name, "_c2_resp"}, {31'b0, resp_valid}, 32'd1);
    checkOutput({name, "_c2_load"}, load_data, 32'd0);
    checkOutput({name, "_c2_mem"}, mem[addr[7:2]], exp_word);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    bench_we     = 1'b0;
    bench_idx    = 6'd0;
    bench_data   = 32'd0;
    reset        = 1'b0;
    setReq(1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    req_valid    = 1'b0;

    //          wr    size   uns   addr       wdata         rd    wr    load          mis   rng
    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h20,  32'h0,        1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h21,  32'h0,        1'b1, 1'b0, 32'h0000007F, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h22,  32'h0,        1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h23,  32'h0,        1'b1, 1'b0, 32'h00000080, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h22,  32'h0,        1'b1, 1'b0, 32'hFFFF80FF, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'h22,  32'h0,        1'b1, 1'b0, 32'h000080FF, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h20,  32'h0,        1'b1, 1'b0, 32'h00007F01, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h22,  32'h0,        1'b1, 1'b0, 32'h000000FF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h12,  32'h0,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h20,  32'h0,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h21,  32'h0,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 2'b10, 1'b0, 32'hFC,  32'h0,        1'b1, 1'b0, 32'h5A5AA5A5, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    checkOutput("rst_load_data", load_data, 32'd0);
    checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_mem_write", {31'b0, mem_write}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    preloadWord(6'd0,  32'h0BADF00D);
    preloadWord(6'd8,  32'h80FF7F01);
    preloadWord(6'd12, 32'h11223344);
    preloadWord(6'd16, 32'hCAFEF00D);
    preloadWord(6'd63, 32'h5A5AA5A5);

    for (int i = 0; i < 16; i++) applyStimulus(i, vecs[i]);
    checkOutput("range_store_no_alias", mem[0], 32'h0BADF00D);

    subwordStore("sb31", 1'b0, 32'h31, 32'hFFFFFFAB, 32'h1122AB44);
    subwordStore("sh32", 1'b1, 32'h32, 32'h1234BEEF, 32'hBEEFAB44);
    subwordStore("sh33", 1'b1, 32'h30, 32'h0000CDEF, 32'hBEEFCDEF);
    subwordStore("sb30", 1'b0, 32'h30, 32'h00000044, 32'hBEEFCD44);

    // Three loads on consecutive cycles give three consecutive responses.
    @(negedge clk);
    setReq(1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    checkOutput("b2b_0_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b_0_data", load_data, 32'h00000001);
    @(negedge clk);
    setReq(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(posedge clk); #1;
    checkOutput("b2b_1_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b_1_data", load_data, 32'hDEADBEEF);
    @(negedge clk);
    setReq(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    @(posedge clk); #1;
    checkOutput("b2b_2_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("b2b_2_data", load_data, 32'h000080FF);
    req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("b2b_idle_resp", {31'b0, resp_valid}, 32'd0);

    // Store byte immediately followed by a load of the same word: the load
    // waits out MERGE and must see the merged value.
    @(negedge clk);
    setReq(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055);
    @(posedge clk); #1;
    @(negedge clk);
    setReq(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    #1;
    checkOutput("sbld_held_ready", {31'b0, req_ready}, 32'd0);
    checkOutput("sbld_held_read", {31'b0, mem_read}, 32'd0);
    @(posedge clk); #1;
    checkOutput("sbld_store_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("sbld_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("sbld_load_read", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("sbld_load_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("sbld_load_data", load_data, 32'hBEEFCD55);

    // Reset while in MERGE: the write drops without a clock edge and the
    // store is abandoned.
    @(negedge clk);
    setReq(1'b1, 2'b00, 1'b0, 32'h40, 32'h00000099);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rmw_rst_pre_write", {31'b0, mem_write}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("rmw_rst_write_drop", {31'b0, mem_write}, 32'd0);
    checkOutput("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rmw_rst_resp", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("rmw_rst_mem", mem[16], 32'hCAFEF00D);
    checkOutput("rmw_rst_resp2", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rmw_rst_after_resp", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    setReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("post_rst_resp", {31'b0, resp_valid}, 32'd1);
    checkOutput("post_rst_data", load_data, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
